// File: rtl/ghist_queue_pkg.sv
// Shared constants, types and pointer helper for the global-history queue.
package ghist_queue_pkg;

  localparam int unsigned DEPTH = 40;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned AW    = 6;

  typedef logic [AW-1:0]    ptr_t;
  typedef logic [WIDTH-1:0] hist_t;

  // DEPTH is not a power of two, so wrap on an explicit compare
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

endpackage

// File: rtl/ghist_queue_if.sv
// Enqueue/dequeue handshake bundle between the predictor and the history queue.
interface ghist_queue_if;
  import ghist_queue_pkg::*;

  logic  flush;
  logic  enq_valid;
  logic  enq_ready;
  hist_t enq_bits;
  logic  deq_valid;
  logic  deq_ready;
  hist_t deq_bits;
  ptr_t  count;

  modport master (
    output flush, enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits, count
  );

  modport slave (
    input  flush, enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits, count
  );

endinterface

// File: rtl/ghist_40x5.sv
// Behavioural stand-in for the 40x5 1R1W history macro: registered read address,
// one-cycle read latency, undefined data on cycles after a disabled read.
module ghist_40x5 (
  input  logic [5:0] R0_addr,
  input  logic       R0_en,
  input  logic       R0_clk,
  output logic [4:0] R0_data,
  input  logic [5:0] W0_addr,
  input  logic       W0_en,
  input  logic       W0_clk,
  input  logic [4:0] W0_data
);

  logic [4:0] ram [0:39];
  logic [5:0] raddr_q;
  logic       ren_q;

  always_ff @(posedge R0_clk) begin
    ren_q <= R0_en;
    if (R0_en) raddr_q <= R0_addr;
  end

  always_ff @(posedge W0_clk) begin
    if (W0_en) ram[W0_addr] <= W0_data;
  end

  assign R0_data = ren_q ? ram[raddr_q] : 'x;

endmodule

// File: rtl/ghist_skid2.sv
// Two-entry ordered output buffer catching macro read data; push and pop may coincide.
module ghist_skid2
  import ghist_queue_pkg::*;
(
  input  logic       clock,
  input  logic       clr,
  input  logic       push,
  input  hist_t      push_data,
  input  logic       pop,
  output logic       out_valid,
  output hist_t      out_data,
  output logic [1:0] cnt
);

  hist_t      e0_q, e1_q, e0_d, e1_d;
  logic [1:0] cnt_q, cnt_d;

  // e0 is always the oldest entry
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/ghist_queue_ctrl.sv
// Circular FIFO controller driving an external 1R1W history macro, with a two-entry
// skid that hides the macro's read latency so dequeue runs at full rate.
module ghist_queue_ctrl
  import ghist_queue_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  ghist_queue_if.slave q,
  output ptr_t  mem_R0_addr,
  output logic  mem_R0_en,
  input  hist_t mem_R0_data,
  output ptr_t  mem_W0_addr,
  output logic  mem_W0_en,
  output hist_t mem_W0_data
);

  ptr_t          tail_q, tail_d, head_q, head_d;
  logic [AW-1:0] mem_cnt_q, mem_cnt_d, tot_q, tot_d;
  logic          rd_inflight_q, rd_inflight_d;
  logic          clr, enq_fire, deq_fire, rd_issue, rd_push, skid_valid;
  logic [1:0]    out_cnt;
  logic [2:0]    skid_occ;
  hist_t         skid_data;

  assign clr         = reset | q.flush;
  assign q.enq_ready = !clr && (tot_q < AW'(DEPTH));
  assign enq_fire    = q.enq_valid & q.enq_ready;
  assign q.deq_valid = skid_valid & !reset;
  assign q.deq_bits  = skid_data;
  assign deq_fire    = q.deq_valid & q.deq_ready & !q.flush;
  assign q.count     = reset ? '0 : tot_q;

  // Issue only when the data returning next cycle is guaranteed a skid slot
  assign skid_occ = 3'(out_cnt) + 3'(rd_inflight_q);
  assign rd_issue = !clr && (mem_cnt_q != '0) && (skid_occ < (3'd2 + 3'(deq_fire)));
  assign rd_push  = rd_inflight_q & !clr;

  assign mem_W0_en   = enq_fire;
  assign mem_W0_addr = reset ? '0 : tail_q;
  assign mem_W0_data = q.enq_bits;
  assign mem_R0_en   = rd_issue;
  assign mem_R0_addr = reset ? '0 : head_q;

  always_comb begin
    tail_d        = tail_q;
    head_d        = head_q;
    mem_cnt_d     = mem_cnt_q;
    tot_d         = tot_q;
    rd_inflight_d = 1'b0;
    if (clr) begin
      tail_d    = '0;
      head_d    = '0;
      mem_cnt_d = '0;
      tot_d     = '0;
    end else begin
      if (enq_fire) tail_d = ptr_inc(tail_q);
      if (rd_issue) head_d = ptr_inc(head_q);
      mem_cnt_d     = mem_cnt_q + AW'(enq_fire) - AW'(rd_issue);
      tot_d         = tot_q + AW'(enq_fire) - AW'(deq_fire);
      rd_inflight_d = rd_issue;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tail_q        <= '0;
      head_q        <= '0;
      mem_cnt_q     <= '0;
      tot_q         <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      tail_q        <= tail_d;
      head_q        <= head_d;
      mem_cnt_q     <= mem_cnt_d;
      tot_q         <= tot_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  ghist_skid2 u_skid (
    .clock     (clock),
    .clr       (clr),
    .push      (rd_push),
    .push_data (mem_R0_data),
    .pop       (deq_fire),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .cnt       (out_cnt)
  );

endmodule

// File: tb/tb_ghist_queue_ctrl.sv
// Bench for ghist_queue_ctrl with the history macro model: directed and random traffic
// against an in-order expected-entry log, checked by a negedge monitor.
module tb_ghist_queue_ctrl;
  import ghist_queue_pkg::*;

  logic  clk = 1'b1;
  logic  reset;
  ptr_t  r_addr, w_addr;
  logic  r_en, w_en;
  hist_t r_data, w_data;

  ghist_queue_if qif();

  always #5 clk = ~clk;

  ghist_queue_ctrl u_dut (
    .clock       (clk),
    .reset       (reset),
    .q           (qif),
    .mem_R0_addr (r_addr),
    .mem_R0_en   (r_en),
    .mem_R0_data (r_data),
    .mem_W0_addr (w_addr),
    .mem_W0_en   (w_en),
    .mem_W0_data (w_data)
  );

  ghist_40x5 u_mem (
    .R0_addr (r_addr),
    .R0_en   (r_en),
    .R0_clk  (clk),
    .R0_data (r_data),
    .W0_addr (w_addr),
    .W0_en   (w_en),
    .W0_clk  (clk),
    .W0_data (w_data)
  );

  // Expected-entry log: driver appends accepted entries, monitor consumes them in order
  hist_t exp_q[$];
  int    wr_idx = 0, clr_mark = 0, wr_prev = 0, exp_count = 0, exp_waddr = 0;
  logic  exp_ready = 1'b0, exp_w_en = 1'b0, cyc_rst = 1'b1, cyc_clr = 1'b1;
  logic  dv_en = 1'b0, dv_val = 1'b0, dn_en = 1'b0, pr_en = 1'b0, em_en = 1'b0;
  hist_t dv_bits = '0;
  int    dn_exp = 0;
  int    rd_idx = 0, iss_idx = 0, deq_total = 0;
  int    errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  // One cycle of stimulus; model occupancy is entries accepted minus entries dequeued
  task automatic cyc(input logic rst, input logic fl, input logic ev, input hist_t bits,
                     input logic dr);
    int mcnt;
    reset         = rst;
    qif.flush     = fl;
    qif.enq_valid = ev;
    qif.enq_bits  = bits;
    qif.deq_ready = dr;
    mcnt      = wr_idx - rd_idx;
    cyc_rst   = rst;
    cyc_clr   = rst | fl;
    exp_ready = !(rst | fl) && (mcnt < int'(DEPTH));
    exp_count = rst ? 0 : mcnt;
    wr_prev   = wr_idx;
    exp_w_en  = ev & exp_ready;
    exp_waddr = (wr_idx - clr_mark) % int'(DEPTH);
    if (exp_w_en) begin
      exp_q.push_back(bits);
      wr_idx++;
    end
    if (rst | fl) clr_mark = wr_idx;
    @(posedge clk);
    #1;
    dv_en = 1'b0;
    dn_en = 1'b0;
    pr_en = 1'b0;
    em_en = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    int   held;
    logic deq_now;
    chk("enq_ready", int'(qif.enq_ready), int'(exp_ready));
    chk("count", int'(qif.count), exp_count);
    chk("w_en", int'(w_en), int'(exp_w_en));
    if (exp_w_en) begin
      chk("w_addr", int'(w_addr), exp_waddr);
      chk("w_data", int'(w_data), int'(exp_q[wr_prev]));
    end
    if (cyc_rst) begin
      chk("rst_deq_valid", int'(qif.deq_valid), 0);
      chk("rst_r_addr", int'(r_addr), 0);
      chk("rst_w_addr", int'(w_addr), 0);
    end
    if (cyc_clr) begin
      chk("clr_r_en", int'(r_en), 0);
      rd_idx  = clr_mark;
      iss_idx = clr_mark;
    end else begin
      held    = iss_idx - rd_idx;
      deq_now = qif.deq_valid & qif.deq_ready;
      if (qif.deq_valid) begin
        chk("deq_has_data", int'(rd_idx < iss_idx), 1);
        if (rd_idx < iss_idx) begin
          chk("deq_bits", int'(qif.deq_bits), int'(exp_q[rd_idx]));
          if (deq_now) begin
            rd_idx++;
            deq_total++;
          end
        end
      end
      if (r_en) begin
        chk("r_addr", int'(r_addr), (iss_idx - clr_mark) % int'(DEPTH));
        chk("r_written", int'(iss_idx < wr_prev), 1);
        chk("skid_room", int'(held + 1 - int'(deq_now) <= 2), 1);
        iss_idx++;
      end
    end
    if (dv_en) begin
      chk("deq_valid", int'(qif.deq_valid), int'(dv_val));
      if (dv_val) chk("deq_bits_dir", int'(qif.deq_bits), int'(dv_bits));
    end
    if (dn_en) chk("deq_rate", deq_total, dn_exp);
    if (em_en) chk("drained", rd_idx, wr_prev);
    if (pr_en) begin
      chk("post_rst_r_en", int'(r_en), 0);
      chk("post_rst_r_addr", int'(r_addr), 0);
      chk("post_rst_w_addr", int'(w_addr), 0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // single entry: deq_valid exactly three cycles after the enqueue
    for (int k = 0; k < 6; k++) begin
      dv_en = 1'b1; dv_val = (k == 3); dv_bits = 5'h15;
      cyc(1'b0, 1'b0, (k == 0), 5'h15, 1'b1);
    end

    // fill to DEPTH with no consumer, try two more, then drain in order
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 5'(i), 1'b0);
    for (int i = 0; i < 2; i++)  cyc(1'b0, 1'b0, 1'b1, 5'h1f, 1'b0);
    for (int i = 0; i < 45; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    em_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // full-rate streaming: 200 dequeues in cycles 3..202 means no bubbles
    base = deq_total;
    for (int i = 0; i < 203; i++) begin
      if (i == 202) begin dn_en = 1'b1; dn_exp = base + 200; end
      cyc(1'b0, 1'b0, (i < 200), 5'(i * 7), 1'b1);
    end
    em_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // random consumer backpressure with a saturating producer
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 1'b0, 1'b1, 5'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    em_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // flush with a read in flight, then a fresh entry
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'b1, 5'(i + 3), 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 5'h11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      dv_en = 1'b1; dv_val = (k == 3); dv_bits = 5'h0A;
      em_en = (k == 4);
      cyc(1'b0, 1'b0, (k == 0), 5'h0A, 1'b1);
    end

    // reset in the middle of traffic
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 5'(i + 9), 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 5'h1b, 1'b1);
    pr_en = 1'b1; dv_en = 1'b1; dv_val = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 5'(i * 3), 1'b1);
    for (int i = 0; i < 8; i++)  cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    em_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
